// File: rtl/div_controller.sv
// ============================================================================
//  Module      : div_controller
//  Description : Control FSM for a SIZE-bit long-division datapath: load,
//                divisor alignment, compare/subtract/shift loop, completion.
//                Optional busy-cycle counter enabled by DIVCTRL_PERF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_controller #(
    parameter int SIZE = 32
`ifdef DIVCTRL_PERF_EN
    ,
    parameter int CYC_W = 16
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic ready,
    output logic busy,
    output logic done,
    output logic div_by_zero,
    output logic init,
    output logic left,
    output logic right,
    output logic sub,
    input  logic cnt_is_0,
    input  logic divisor_is_0,
    input  logic dvsr_less_than_dvnd,
    input  logic shifted_divisor_MSB
`ifdef DIVCTRL_PERF_EN
    ,
    output logic [CYC_W-1:0] cycles
`endif
);

    localparam int c_ALIGN_W = (SIZE > 2) ? $clog2(SIZE) : 1;
    localparam logic [c_ALIGN_W-1:0] c_ALIGN_MAX = c_ALIGN_W'(SIZE - 1);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_INIT  = 4'd1;
    localparam logic [3:0] c_CHECK = 4'd2;
    localparam logic [3:0] c_ALIGN = 4'd3;
    localparam logic [3:0] c_CMP   = 4'd4;
    localparam logic [3:0] c_SUB   = 4'd5;
    localparam logic [3:0] c_SHIFT = 4'd6;
    localparam logic [3:0] c_DONE  = 4'd7;
    localparam logic [3:0] c_ERR   = 4'd8;

    logic [3:0]           r_state;
    logic [3:0]           w_next_state;
    logic [c_ALIGN_W-1:0] r_align_cnt;
    logic                 w_align_go;
    logic                 w_accept;

    // Alignment continues only while the shifted divisor still fits under the
    // dividend and has room to grow; the count bounds it even on bad status.
    assign w_align_go = !shifted_divisor_MSB && dvsr_less_than_dvnd &&
                        (r_align_cnt < c_ALIGN_MAX);
    assign w_accept   = (r_state == c_IDLE) && start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  w_next_state = start ? c_INIT : c_IDLE;
            c_INIT:  w_next_state = c_CHECK;
            c_CHECK: w_next_state = divisor_is_0 ? c_ERR : c_ALIGN;
            c_ALIGN: w_next_state = w_align_go ? c_ALIGN : c_CMP;
            c_CMP:   w_next_state = dvsr_less_than_dvnd ? c_SUB : c_SHIFT;
            c_SUB:   w_next_state = c_SHIFT;
            c_SHIFT: w_next_state = cnt_is_0 ? c_DONE : c_CMP;
            c_DONE:  w_next_state = c_IDLE;
            c_ERR:   w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Outputs depend on the state register and datapath status only.
    always_comb begin
        ready       = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        div_by_zero = 1'b0;
        init        = 1'b0;
        left        = 1'b0;
        right       = 1'b0;
        sub         = 1'b0;
        case (r_state)
            c_IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
            end
            c_INIT:  init  = 1'b1;
            c_ALIGN: left  = w_align_go;
            c_SUB:   sub   = 1'b1;
            c_SHIFT: right = !cnt_is_0;
            c_DONE:  done  = 1'b1;
            c_ERR: begin
                done        = 1'b1;
                div_by_zero = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_align_cnt <= '0;
        end else if (w_accept) begin
            r_align_cnt <= '0;
        end else if ((r_state == c_ALIGN) && w_align_go) begin
            r_align_cnt <= r_align_cnt + 1'b1;
        end
    end

`ifdef DIVCTRL_PERF_EN
    localparam logic [CYC_W-1:0] c_CYC_MAX = '1;

    logic [CYC_W-1:0] r_perf_cnt;
    logic [CYC_W-1:0] r_cycles;
    logic [CYC_W-1:0] w_perf_next;

    assign w_perf_next = (r_perf_cnt == c_CYC_MAX) ? c_CYC_MAX : r_perf_cnt + 1'b1;

    // The latched figure includes the DONE/ERR cycle itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_cnt <= '0;
            r_cycles   <= '0;
        end else begin
            if (w_accept) begin
                r_perf_cnt <= '0;
            end else if (r_state != c_IDLE) begin
                r_perf_cnt <= w_perf_next;
            end
            if ((r_state == c_DONE) || (r_state == c_ERR)) begin
                r_cycles <= w_perf_next;
            end
        end
    end

    assign cycles = r_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_div_controller.sv
// ============================================================================
//  Module      : tb_div_controller
//  Description : Scoreboard bench for div_controller driving a behavioural
//                long-division datapath; directed operand vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_controller;

    localparam int SIZE = 32;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic ready, busy, done, div_by_zero, init, left, right, sub;
    logic cnt_is_0, divisor_is_0, dvsr_less_than_dvnd, shifted_divisor_MSB;
`ifdef DIVCTRL_PERF_EN
    logic [15:0] cycles;
`endif

    div_controller #(.SIZE(SIZE)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .ready               (ready),
        .busy                (busy),
        .done                (done),
        .div_by_zero         (div_by_zero),
        .init                (init),
        .left                (left),
        .right               (right),
        .sub                 (sub),
        .cnt_is_0            (cnt_is_0),
        .divisor_is_0        (divisor_is_0),
        .dvsr_less_than_dvnd (dvsr_less_than_dvnd),
        .shifted_divisor_MSB (shifted_divisor_MSB)
`ifdef DIVCTRL_PERF_EN
        ,
        .cycles              (cycles)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural datapath: restoring division with a left/right shift count.
    logic [31:0] op_a, op_b;
    logic [31:0] dp_rem, dp_dvsr, dp_quot;
    logic [5:0]  dp_cnt;

    always_ff @(posedge clk) begin
        if (init) begin
            dp_rem  <= op_a;
            dp_dvsr <= op_b;
            dp_quot <= '0;
            dp_cnt  <= '0;
        end else if (left) begin
            dp_dvsr <= dp_dvsr << 1;
            dp_cnt  <= dp_cnt + 6'd1;
        end else if (sub) begin
            dp_rem  <= dp_rem - dp_dvsr;
            dp_quot <= dp_quot | 32'd1;
        end else if (right) begin
            dp_dvsr <= dp_dvsr >> 1;
            dp_cnt  <= dp_cnt - 6'd1;
            dp_quot <= dp_quot << 1;
        end
    end

    assign cnt_is_0            = (dp_cnt == 6'd0);
    assign divisor_is_0        = (dp_dvsr == 32'd0);
    assign dvsr_less_than_dvnd = (dp_dvsr <= dp_rem);
    assign shifted_divisor_MSB = dp_dvsr[31];

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          lat;
        int          nl;
        int          ns;
        int          nr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   done_cnt = 0;
    int   tick = 0;
    int   prev_done_tick = 0;
    int   last_done_tick = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: measures each operation and compares against the scoreboard on done.
    bit in_op = 1'b0;
    int op_cyc, cl, cs, cr, multi;

    always @(negedge clk) begin
        exp_t e;
        tick++;
        if (reset) begin
            in_op = 1'b0;
        end else begin
            if (init) begin
                in_op = 1'b1;
                op_cyc = 0; cl = 0; cs = 0; cr = 0; multi = 0;
            end
            if (in_op) begin
                op_cyc++;
                cl += int'(left);
                cs += int'(sub);
                cr += int'(right);
                if ((int'(init) + int'(left) + int'(right) + int'(sub)) > 1) multi++;
            end
            if (div_by_zero && !done) check("dbz_without_done", 64'(div_by_zero), 64'(0));
            if (done) begin
                done_cnt++;
                prev_done_tick = last_done_tick;
                last_done_tick = tick;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("latency",     64'(op_cyc), 64'(e.lat));
                    check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                    check("left_count",  64'(cl), 64'(e.nl));
                    check("sub_count",   64'(cs), 64'(e.ns));
                    check("right_count", 64'(cr), 64'(e.nr));
                    check("ctrl_overlap", 64'(multi), 64'(0));
                    if (!e.dbz) begin
                        check("quotient",  64'(dp_quot), 64'(e.q));
                        check("remainder", 64'(dp_rem), 64'(e.r));
                    end
                end
                in_op = 1'b0;
            end
        end
    end

    task automatic wait_done(input int target);
        bit got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            if (done_cnt >= target) got = 1'b1;
        end
        if (!got) check("done_timeout", 64'(done_cnt), 64'(target));
    endtask

    task automatic push_exp(input logic [31:0] q, input logic [31:0] r, input logic dbz,
                            input int lat, input int nl, input int ns, input int nr);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.lat = lat; e.nl = nl; e.ns = ns; e.nr = nr;
        exp_q.push_back(e);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] q, input logic [31:0] r, input logic dbz,
                          input int lat, input int nl, input int ns, input int nr);
        int target;
        op_a = a;
        op_b = b;
        push_exp(q, r, dbz, lat, nl, ns, nr);
        target = done_cnt + 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(target);
`ifdef DIVCTRL_PERF_EN
        check("perf_cycles", 64'(cycles), 64'(lat));
`endif
    endtask

    function automatic logic [7:0] outs();
        return {ready, busy, done, div_by_zero, init, left, right, sub};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 64'(outs()), 64'(8'b1000_0000));
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_outputs", 64'(outs()), 64'(8'b1000_0000));
`ifdef DIVCTRL_PERF_EN
        check("reset_cycles", 64'(cycles), 64'(0));
`endif

        // Reset while aligning: async return to IDLE, no done pulse afterwards.
        op_a  = 32'hFFFF_FFFF;
        op_b  = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_align_left", 64'({busy, left}), 64'(2'b11));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_outputs", 64'(outs()), 64'(8'b1000_0000));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", 64'(outs()), 64'(8'b1000_0000));

        //       dividend      divisor       q             r            dbz lat  k   s   r
        run_op(32'd7,        32'd2,        32'd3,        32'd1,        0, 14,  2,  2,  2);
        run_op(32'd5,        32'd0,        32'd0,        32'd0,        1,  3,  0,  0,  0);
        run_op(32'd3,        32'd8,        32'd0,        32'd3,        0,  6,  0,  0,  0);
        run_op(32'd6,        32'd3,        32'd2,        32'd0,        0, 13,  2,  1,  2);
        run_op(32'd5,        32'd5,        32'd1,        32'd0,        0, 10,  1,  1,  1);
        run_op(32'd7,        32'h8000_0000, 32'd0,       32'd7,        0,  6,  0,  0,  0);
        run_op(32'h8000_0000, 32'd1,       32'h8000_0000, 32'd0,       0, 100, 31,  1, 31);
        run_op(32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0,       0, 131, 31, 32, 31);

        // start held high across two ops: second accepted only from IDLE after done.
        begin
            int target;
            op_a = 32'd7;
            op_b = 32'd2;
            push_exp(32'd3, 32'd1, 1'b0, 14, 2, 2, 2);
            push_exp(32'd3, 32'd1, 1'b0, 14, 2, 2, 2);
            target = done_cnt + 2;
            start = 1'b1;
            wait_done(target);
            start = 1'b0;
            check("b2b_spacing", 64'(last_done_tick - prev_done_tick), 64'(15));
`ifdef DIVCTRL_PERF_EN
            check("b2b_perf_cycles", 64'(cycles), 64'(14));
`endif
            repeat (3) @(posedge clk);
            #1;
            check("no_extra_accept", 64'(busy), 64'(0));
        end

        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
